// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM definitions for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;
    localparam logic [3:0] ALU_REMU = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // True for the opcodes served by the iterative unit.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// A start loads the operands; WIDTH steps later done is raised for one cycle
// while res presents the combinational value of the final step.
module alu_mc_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic             is_div,
    input  logic             want_rem,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH);

    // acc: product (MUL) or partial remainder (DIV)
    // x:   shifted multiplicand (MUL) or dividend shifting into quotient (DIV)
    // y:   shifted multiplier (MUL) or divisor (DIV)
    logic [WIDTH-1:0] acc_reg, x_reg, y_reg;
    logic [CW-1:0]    cnt_reg;
    logic             run_reg, div_reg, rem_reg;

    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             rem_ok;
    logic [WIDTH-1:0] div_rem_next, div_quo_next;

    // One step of each algorithm from the current registers.
    always_comb begin
        mul_acc_next = acc_reg + (y_reg[0] ? x_reg : '0);
        rem_shift    = {acc_reg, x_reg[WIDTH-1]};
        rem_diff     = rem_shift - {1'b0, y_reg};
        rem_ok       = ~rem_diff[WIDTH];
        div_rem_next = rem_ok ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        div_quo_next = {x_reg[WIDTH-2:0], rem_ok};
    end

    // The last step is never written back; it goes straight to the caller.
    assign done = run_reg && (cnt_reg == '0);
    assign res  = !div_reg ? mul_acc_next : (rem_reg ? div_rem_next : div_quo_next);

    // Operand load on start, then one iteration per cycle until the count expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
            div_reg <= 1'b0;
            rem_reg <= 1'b0;
        end else if (clear) begin
            run_reg <= 1'b0;
        end else if (start) begin
            acc_reg <= '0;
            x_reg   <= a;
            y_reg   <= b;
            cnt_reg <= CW'(WIDTH - 1);
            run_reg <= 1'b1;
            div_reg <= is_div;
            rem_reg <= want_rem;
        end else if (run_reg) begin
            if (cnt_reg == '0) begin
                run_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
                if (div_reg) begin
                    acc_reg <= div_rem_next;
                    x_reg   <= div_quo_next;
                end else begin
                    acc_reg <= mul_acc_next;
                    x_reg   <= x_reg << 1;
                    y_reg   <= y_reg >> 1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready handshakes on both sides.
// Simple ops finish at acceptance; MUL/DIVU/REMU go through alu_mc_iter.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] iter_res;
    logic             iter_done;
    logic             accept, is_md, iter_start;
    logic [SHW-1:0]   shamt;

    assign shamt      = b[SHW-1:0];
    assign is_md      = MULDIV_EN && is_muldiv(op);
    assign accept     = in_valid && (state_reg == ST_IDLE) && !flush;
    assign iter_start = accept && is_md;

    // Single-cycle datapath; iterative opcodes fall to 0 here, which is
    // exactly the answer when the iterative unit is left out.
    always_comb begin
        alu_out = '0;
        case (op)
            ALU_ADD:  alu_out = a + b;
            ALU_SUB:  alu_out = a - b;
            ALU_AND:  alu_out = a & b;
            ALU_OR:   alu_out = a | b;
            ALU_XOR:  alu_out = a ^ b;
            ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  alu_out = a << shamt;
            ALU_SRL:  alu_out = a >> shamt;
            ALU_SRA:  alu_out = $signed(a) >>> shamt;
            default:  alu_out = '0;
        endcase
    end

    generate
        if (MULDIV_EN) begin : g_iter
            alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
                .clk      (clk),
                .rst      (rst),
                .clear    (flush),
                .start    (iter_start),
                .is_div   (op != ALU_MUL),
                .want_rem (op == ALU_REMU),
                .a        (a),
                .b        (b),
                .done     (iter_done),
                .res      (iter_res)
            );
        end else begin : g_no_iter
            assign iter_done = 1'b0;
            assign iter_res  = '0;
        end
    endgenerate

    // Next-state decode; flush wins over everything else.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)    state_next = is_md ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Result and zero flag are captured together and otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
            zero_reg   <= 1'b1;
        end else if (!flush) begin
            if (accept && !is_md) begin
                result_reg <= alu_out;
                zero_reg   <= (alu_out == '0);
            end else if ((state_reg == ST_BUSY) && iter_done) begin
                result_reg <= iter_res;
                zero_reg   <= (iter_res == '0);
            end
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_BUSY);
    assign result    = result_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: cycle-level behavioural model plus
// directed literal checks and randomized operations.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, zero, busy;
    logic [W-1:0] result;

    int total = 0;
    int bad = 0;

    alu_mc #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain arithmetic.
    function automatic logic [W-1:0] ref_fn(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int sh;
        logic [W-1:0] r;
        sh = int'(y % W);
        case (o)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'd6:  r = (x < y) ? 1 : 0;
            4'd7:  r = x << sh;
            4'd8:  r = x >> sh;
            4'd9:  r = $signed(x) >>> sh;
            4'd10: r = x * y;
            4'd11: r = (y == 0) ? '1 : x / y;
            4'd12: r = (y == 0) ? x : x % y;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic slow_op(input logic [3:0] o);
        return (o >= 4'd10) && (o <= 4'd12);
    endfunction

    // Model: 0 = waiting for operands, 1 = computing (m_cnt cycles left), 2 = holding result.
    int           m_state = 0;
    int           m_cnt = 0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_res   <= '0;
        end else if (flush) begin
            m_state <= 0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    if (slow_op(op)) begin
                        m_state <= 1;
                        m_cnt   <= W;
                        m_pend  <= ref_fn(op, a, b);
                    end else begin
                        m_state <= 2;
                        m_res   <= ref_fn(op, a, b);
                    end
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_state <= 2;
                        m_res   <= m_pend;
                    end
                end
                default: if (out_ready) m_state <= 0;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk_bit("in_ready", in_ready, m_state == 0);
            chk_bit("busy", busy, m_state == 1);
            chk_bit("out_valid", out_valid, m_state == 2);
            chk_word("result", result, m_res);
            chk_bit("zero", zero, m_res == '0);
        end
    end

    // Issue one op, stir ignored inputs while waiting, hold the result for
    // 'hold' cycles, then consume it.
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold, input logic chk_lit, input logic [W-1:0] lit);
        int k;
        int nbusy;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
        @(posedge clk);
        k = 0;
        nbusy = 0;
        while (1) begin
            @(negedge clk);
            k++;
            if (out_valid || k > 100) break;
            if (busy) nbusy++;
            in_valid = 1'($urandom); op = 4'($urandom); a = $urandom; b = $urandom;
        end
        chk_word("latency", k, slow_op(o) ? W + 1 : 1);
        chk_word("busy_cycles", nbusy, slow_op(o) ? W : 0);
        if (chk_lit) begin
            chk_word("lit_result", result, lit);
            chk_bit("lit_zero", zero, lit == '0);
        end
        repeat (hold) begin
            @(negedge clk);
            in_valid = 1'($urandom); op = 4'($urandom); a = $urandom; b = $urandom;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk_bit("in_ready_after", in_ready, 1'b1);
        out_ready = 1'b0;
        $display("op=%h a=%h b=%h -> result=%h latency=%0d", o, x, y, result, k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   o;
        logic [W-1:0] x, y;

        repeat (2) @(negedge clk);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_word("rst_result", result, '0);
        chk_bit("rst_zero", zero, 1'b1);
        rst = 1'b0;

        do_op(4'd0,  32'hFFFF_FFFF, 32'h1,         0, 1'b1, 32'h0);
        do_op(4'd5,  32'hFFFF_FFFE, 32'h1,         0, 1'b1, 32'h1);
        do_op(4'd6,  32'hFFFF_FFFE, 32'h1,         0, 1'b1, 32'h0);
        do_op(4'd9,  32'h8000_0000, 32'h24,        0, 1'b1, 32'hF800_0000);
        do_op(4'd10, 32'h0001_2345, 32'h0001_0000, 0, 1'b1, 32'h2345_0000);
        do_op(4'd11, 32'd100,       32'd7,         0, 1'b1, 32'd14);
        do_op(4'd12, 32'd100,       32'd7,         0, 1'b1, 32'd2);
        do_op(4'd11, 32'd5,         32'd0,         0, 1'b1, 32'hFFFF_FFFF);
        do_op(4'd12, 32'd5,         32'd0,         0, 1'b1, 32'd5);
        do_op(4'd0,  32'd3,         32'd4,         5, 1'b1, 32'd7);

        // Flush during the tenth DIVU iteration.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd11; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_bit("flush_out_valid", out_valid, 1'b0);
        chk_bit("flush_in_ready", in_ready, 1'b1);
        chk_bit("flush_busy", busy, 1'b0);
        chk_word("flush_result", result, 32'd7);
        $display("flush mid-DIVU -> in_ready=%b out_valid=%b", in_ready, out_valid);

        // Op presented together with flush is dropped.
        in_valid = 1'b1; flush = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk_bit("flush_drop_in_ready", in_ready, 1'b1);
        chk_bit("flush_drop_out_valid", out_valid, 1'b0);
        $display("flush with in_valid -> dropped, in_ready=%b", in_ready);

        // Asynchronous reset in the middle of a multiply.
        in_valid = 1'b1; op = 4'd10; a = 32'h1234; b = 32'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_bit("arst_in_ready", in_ready, 1'b1);
        chk_bit("arst_out_valid", out_valid, 1'b0);
        chk_bit("arst_busy", busy, 1'b0);
        chk_word("arst_result", result, '0);
        chk_bit("arst_zero", zero, 1'b1);
        $display("reset mid-MUL -> result=%h zero=%b", result, zero);
        @(negedge clk);
        rst = 1'b0;
        do_op(4'd0, 32'd1, 32'd1, 0, 1'b1, 32'd2);

        // Randomized operations, every opcode including the unused ones.
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom);
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            do_op(o, x, y, $urandom_range(0, 2), 1'b1, ref_fn(o, x, y));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
